// File: rtl/game_control.sv
// -----------------------------------------------------------------------------
// game_control
//
// Frame sequencer for a flappy-bird style game. Walks the drawing datapath
// through draw / wait / clear / update / check phases once per video frame,
// latches flap key presses until the next position update consumes them, and
// keeps the score (walls passed, saturating at 255).
//
// Parameters
//   FRAME_TICKS  clk cycles per game frame (2..1048575)
//   FLAP_HOLD    frames a flap press stays latched without being consumed (>=1)
//
// Ports
//   clk            system clock, everything on its rising edge
//   reset          synchronous, active-high reset
//   start          level, begins play from IDLE or GAME_OVER
//   flap           level, synchronised key press (rising edge is a flap)
//   finished_draw  one-cycle pulse, current rectangle complete
//   collision      level, bird overlaps wall or screen edge
//   wall_wrap      level, wall respawned at the right edge this update
//   pause          (GAME_CONTROL_PAUSE_EN only) rising edge toggles pause
//   cur_state      4-bit state code to the drawing datapath
//   erase          high in the CLEAR_* states (background colour)
//   update_en      one-cycle pulse while in UPDATE
//   flap_out       valid with update_en, bird moves up this step
//   score          walls passed since start
//   game_over      high while in GAME_OVER
//
// Optional feature: define GAME_CONTROL_PAUSE_EN to add the pause input and a
// pause flag, toggled by a pause rising edge or by a flap rising edge while
// start is held. While paused the frame counter stalls and UPDATE is not
// entered.
// -----------------------------------------------------------------------------
module game_control #(
   parameter int unsigned FRAME_TICKS = 833333,
   parameter int unsigned FLAP_HOLD   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       flap,
   input  logic       finished_draw,
   input  logic       collision,
   input  logic       wall_wrap,
`ifdef GAME_CONTROL_PAUSE_EN
   input  logic       pause,
`endif
   output logic [3:0] cur_state,
   output logic       erase,
   output logic       update_en,
   output logic       flap_out,
   output logic [7:0] score,
   output logic       game_over
);

   typedef enum logic [3:0] {
      DRAW_BIRD      = 4'd0,
      DRAW_WALL_TOP  = 4'd1,
      DRAW_WALL_BOT  = 4'd2,
      CLEAR_BIRD     = 4'd3,
      CLEAR_WALL_TOP = 4'd4,
      CLEAR_WALL_BOT = 4'd5,
      WAIT_FRAME     = 4'd6,
      UPDATE         = 4'd7,
      CHECK          = 4'd8,
      GAME_OVER      = 4'd9,
      IDLE           = 4'd10
   } state_t;

   localparam logic [19:0] FRAME_LAST = 20'(FRAME_TICKS - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(FLAP_HOLD - 1);

   state_t      state_reg, state_next;
   logic [19:0] frame_cnt_reg;
   logic        flap_d_reg;
   logic        flap_latch_reg;
   logic [15:0] hold_cnt_reg;
   logic        wrap_seen_reg;
   logic [7:0]  score_reg;
   logic        update_en_reg;
   logic        flap_out_reg;

   logic        paused;
   logic        pause_toggle;
   logic        bot_done;
   logic        play_start;
   logic        frame_done;
   logic        flap_rise;
   logic        in_play;
   logic        flap_set;

`ifdef GAME_CONTROL_PAUSE_EN
   logic pause_reg;
   logic pause_d_reg;
   logic bot_done_reg;

   assign pause_toggle = (flap_rise && start) || (pause && !pause_d_reg);
   assign paused       = pause_reg;
   // A finished_draw in CLEAR_WALL_BOT may arrive while paused; remember it so
   // the handshake is not lost and UPDATE follows as soon as play resumes.
   assign bot_done     = finished_draw || bot_done_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         pause_reg    <= 1'b0;
         pause_d_reg  <= 1'b0;
         bot_done_reg <= 1'b0;
      end else begin
         pause_d_reg <= pause;
         if (pause_toggle)
            pause_reg <= ~pause_reg;
         if (state_reg != CLEAR_WALL_BOT)
            bot_done_reg <= 1'b0;
         else if (finished_draw)
            bot_done_reg <= 1'b1;
      end
   end
`else
   assign pause_toggle = 1'b0;
   assign paused       = 1'b0;
   assign bot_done     = finished_draw;
`endif

   assign flap_rise  = flap && !flap_d_reg;
   // IDLE, GAME_OVER and the illegal codes above them are not play states.
   assign in_play    = (state_reg <= CHECK);
   // A flap edge used to toggle pause is not also a flap request.
   assign flap_set   = flap_rise && in_play && !pause_toggle;
   assign frame_done = (state_reg == WAIT_FRAME) && !paused &&
                       (frame_cnt_reg == FRAME_LAST);

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      play_start = 1'b0;
      case (state_reg)
         IDLE, GAME_OVER: begin
            if (start) begin
               state_next = DRAW_BIRD;
               play_start = 1'b1;
            end
         end
         DRAW_BIRD:      if (finished_draw) state_next = DRAW_WALL_TOP;
         DRAW_WALL_TOP:  if (finished_draw) state_next = DRAW_WALL_BOT;
         DRAW_WALL_BOT:  if (finished_draw) state_next = WAIT_FRAME;
         WAIT_FRAME:     if (frame_done)    state_next = CLEAR_BIRD;
         CLEAR_BIRD:     if (finished_draw) state_next = CLEAR_WALL_TOP;
         CLEAR_WALL_TOP: if (finished_draw) state_next = CLEAR_WALL_BOT;
         CLEAR_WALL_BOT: if (bot_done && !paused) state_next = UPDATE;
         UPDATE:         state_next = CHECK;
         CHECK:          state_next = collision ? GAME_OVER : DRAW_BIRD;
         default:        state_next = IDLE;
      endcase
   end

   // State register, frame counter and registered pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         frame_cnt_reg <= '0;
         update_en_reg <= 1'b0;
         flap_out_reg  <= 1'b0;
         flap_d_reg    <= 1'b0;
         wrap_seen_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         flap_d_reg <= flap;

         if (state_reg != WAIT_FRAME || frame_done)
            frame_cnt_reg <= '0;
         else if (!paused)
            frame_cnt_reg <= frame_cnt_reg + 20'd1;

         // Both pulses are launched on the edge that enters UPDATE, so they
         // line up with the UPDATE state code. A flap edge on that same edge
         // still makes it into this update.
         update_en_reg <= (state_next == UPDATE);
         flap_out_reg  <= (state_next == UPDATE) && (flap_latch_reg || flap_set);

         if (state_reg == UPDATE)
            wrap_seen_reg <= wall_wrap;
      end
   end

   // Flap latch with frame-based expiry
   always_ff @(posedge clk) begin
      if (reset || play_start) begin
         flap_latch_reg <= 1'b0;
         hold_cnt_reg   <= '0;
      end else if (state_reg == UPDATE) begin
         // Consumed by this update; an edge arriving now belongs to the next.
         flap_latch_reg <= flap_set;
         hold_cnt_reg   <= '0;
      end else if (flap_set) begin
         flap_latch_reg <= 1'b1;
         hold_cnt_reg   <= '0;
      end else if (flap_latch_reg && frame_done) begin
         if (hold_cnt_reg >= HOLD_LAST) begin
            flap_latch_reg <= 1'b0;
            hold_cnt_reg   <= '0;
         end else begin
            hold_cnt_reg <= hold_cnt_reg + 16'd1;
         end
      end
   end

   // Score
   always_ff @(posedge clk) begin
      if (reset || play_start)
         score_reg <= '0;
      else if (state_reg == CHECK && !collision && wrap_seen_reg &&
               score_reg != 8'hFF)
         score_reg <= score_reg + 8'd1;
   end

   assign cur_state = state_reg;
   assign erase     = (state_reg == CLEAR_BIRD) || (state_reg == CLEAR_WALL_TOP) ||
                      (state_reg == CLEAR_WALL_BOT);
   assign game_over = (state_reg == GAME_OVER);
   assign update_en = update_en_reg;
   assign flap_out  = flap_out_reg;
   assign score     = score_reg;

endmodule

// File: doc/game_control.md
GAME_CONTROL -- requirements
Module: game_control

Interface
REQ-001 Parameter FRAME_TICKS, default 833333, clk cycles per game frame (60 Hz at 50 MHz); legal range 2..1048575.
REQ-002 Parameter FLAP_HOLD, default 3, frames the flap request remains latched before it is dropped.
REQ-003 clk  in  1  system clock; the block has one clock and all logic is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  level; begins play from IDLE or GAME_OVER.
REQ-006 flap  in  1  level, already synchronised key press.
REQ-007 finished_draw  in  1  one-cycle pulse from the drawing datapath; the current rectangle is complete.
REQ-008 collision  in  1  level from the drawing datapath; bird overlaps wall or screen edge.
REQ-009 wall_wrap  in  1  level; wall respawned at the right edge during this frame's update.
REQ-010 cur_state  out  4  state code driven to the drawing datapath.
REQ-011 erase  out  1  high in CLEAR_* states; the datapath selects background colour.
REQ-012 update_en  out  1  one-cycle pulse; bird and wall positions advance one step.
REQ-013 flap_out  out  1  valid with update_en; bird moves up this step instead of falling.
REQ-014 score  out  8  walls passed since start.
REQ-015 game_over  out  1  high while in GAME_OVER.

Function
REQ-016 Codes: DRAW_BIRD=0, DRAW_WALL_TOP=1, DRAW_WALL_BOT=2, CLEAR_BIRD=3, CLEAR_WALL_TOP=4, CLEAR_WALL_BOT=5, WAIT_FRAME=6, UPDATE=7, CHECK=8, GAME_OVER=9, IDLE=10; codes 11-15 go to IDLE next cycle.
REQ-017 IDLE -> DRAW_BIRD on start=1.
REQ-018 DRAW_BIRD -> DRAW_WALL_TOP -> DRAW_WALL_BOT -> WAIT_FRAME; each DRAW_*/CLEAR_* state advances only on the cycle after finished_draw=1 and otherwise holds.
REQ-019 A finished_draw pulse received outside DRAW_*/CLEAR_* states is ignored.
REQ-020 WAIT_FRAME: 20-bit frame counter counts 0..FRAME_TICKS-1; on terminal count go to CLEAR_BIRD and clear counter; counter is held at 0 in all other states.
REQ-021 CLEAR_BIRD -> CLEAR_WALL_TOP -> CLEAR_WALL_BOT -> UPDATE, with the same finished_draw handshake.
REQ-022 UPDATE lasts exactly one cycle: update_en=1, flap_out = flap latch; latch cleared; next state CHECK.
REQ-023 CHECK lasts one cycle: collision=1 -> GAME_OVER, else DRAW_BIRD.
REQ-024 Flap latch is set by a rising edge of flap in any play state; it drops after FLAP_HOLD frames without an UPDATE consuming it.
REQ-025 score increments by 1 in CHECK when wall_wrap was high during UPDATE and collision=0; saturates at 255.
REQ-026 score clears on the start transition out of IDLE or GAME_OVER.
REQ-027 GAME_OVER holds score and returns to DRAW_BIRD on start=1.
REQ-028 erase and game_over are decoded combinationally from the state register; update_en is a registered pulse aligned to the UPDATE state.

Reset
REQ-029 On reset=1 at a clock edge: state=IDLE, cur_state=10, counter=0, flap latch=0, score=0, update_en=0, flap_out=0, erase=0, game_over=0.
REQ-030 Reset asserted mid-draw abandons the handshake; a finished_draw pulse arriving in the same cycle as reset is discarded.

Configuration
REQ-031 Macro GAME_CONTROL_PAUSE_EN defined: the pause input is present; a rising edge of flap held together with start toggles a pause flag; while paused, WAIT_FRAME does not count and UPDATE is not entered; reset clears the flag.
REQ-032 Macro GAME_CONTROL_PAUSE_EN undefined: no pause logic, and behaviour matches REQ-016..REQ-030 exactly.

Verification
REQ-033 Reset, then start=1 for one cycle -> cur_state 10 -> 0; state holds at 0 until finished_draw; the pulse steps 0 -> 1 -> 2 -> 6.
REQ-034 FRAME_TICKS=4 in WAIT_FRAME -> CLEAR_BIRD is entered exactly 4 cycles after entry; erase=1 in states 3-5.
REQ-035 flap pulse during WAIT_FRAME -> flap_out=1 with the next update_en; the following frame has flap_out=0.
REQ-036 collision=1 in CHECK -> cur_state=9, game_over=1, score held; start -> score=0, cur_state=0.
REQ-037 wall_wrap=1 on 256 frames -> score saturates at 255.
REQ-038 reset asserted in state 4 together with finished_draw -> next cycle cur_state=10 and all outputs at reset values.
